// File: rtl/swt_debounce.sv
`default_nettype none
// ============================================================================
// Module   : swt_debounce
// Purpose  : Per-channel switch/button conditioner. Each channel passes its
//            raw input through a 2-flop synchronizer, then accepts a new
//            level only after it has been seen unchanged for P_CNT_MAX
//            consecutive cycles. It produces a clean level, single-cycle
//            rise/fall pulses, and a latch that toggles on every rise.
// Ports    : clk      - single clock, rising edge
//            rstb     - asynchronous active-low reset, clears every flop
//            i_swt    - raw switch levels, asynchronous to clk [P_NCH]
//            o_swt    - debounced level, registered             [P_NCH]
//            o_rise   - one-cycle pulse on o_swt 0->1           [P_NCH]
//            o_fall   - one-cycle pulse on o_swt 1->0           [P_NCH]
//            o_latch  - toggles on every o_rise                 [P_NCH]
// Revision : 1.0 - initial release
// ============================================================================
module swt_debounce #(
    parameter int P_NCH     = 4,
    parameter int P_CNT_MAX = 1000000,
    parameter int P_CNT_W   = 20
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [P_NCH-1:0] i_swt,
    output logic [P_NCH-1:0] o_swt,
    output logic [P_NCH-1:0] o_rise,
    output logic [P_NCH-1:0] o_fall,
    output logic [P_NCH-1:0] o_latch
);

    // Terminal count: the candidate level has been observed on P_CNT_MAX
    // consecutive edges once the counter sits at this value and still differs.
    localparam logic [P_CNT_W-1:0] C_CNT_LAST = P_CNT_W'(P_CNT_MAX - 1);
    localparam logic [P_CNT_W-1:0] C_CNT_ONE  = P_CNT_W'(1);

    logic [P_NCH-1:0] s1_q;
    logic [P_NCH-1:0] s2_q;
    logic [P_NCH-1:0] swt_q;
    logic [P_NCH-1:0] swt_d;
    logic [P_NCH-1:0] rise_q;
    logic [P_NCH-1:0] rise_d;
    logic [P_NCH-1:0] fall_q;
    logic [P_NCH-1:0] fall_d;
    logic [P_NCH-1:0] latch_q;
    logic [P_NCH-1:0] latch_d;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer; only s2 is used by the qualification logic.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= i_swt;
            s2_q <= s1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel stability counter and level update.
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < P_NCH; g++) begin : g_ch
            logic [P_CNT_W-1:0] cnt_q;
            logic [P_CNT_W-1:0] cnt_d;
            logic               lvl_d;

            always_comb begin
                cnt_d = cnt_q;
                lvl_d = swt_q[g];
                if (s2_q[g] == swt_q[g]) begin
                    // Agreement (including a bounce back) restarts qualification.
                    cnt_d = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    lvl_d = s2_q[g];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign swt_d[g] = lvl_d;
        end
    endgenerate

    // Pulses and latch are derived from the next level so they update on the
    // same edge as o_swt rather than one cycle later.
    assign rise_d  = swt_d & ~swt_q;
    assign fall_d  = ~swt_d & swt_q;
    assign latch_d = latch_q ^ rise_d;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            swt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            latch_q <= '0;
        end else begin
            swt_q   <= swt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            latch_q <= latch_d;
        end
    end

    assign o_swt   = swt_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_latch = latch_q;

endmodule
`default_nettype wire

// File: tb/tb_swt_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_swt_debounce
// Purpose  : Directed self-checking bench for swt_debounce with
//            P_CNT_MAX=4, P_NCH=4. Inputs change and outputs are sampled on
//            the falling edge; the first rising edge after a change is edge 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swt_debounce;

    localparam int C_NCH = 4;

    logic             clk;
    logic             rstb;
    logic [C_NCH-1:0] i_swt;
    logic [C_NCH-1:0] o_swt;
    logic [C_NCH-1:0] o_rise;
    logic [C_NCH-1:0] o_fall;
    logic [C_NCH-1:0] o_latch;

    int checks   = 0;
    int failures = 0;

    swt_debounce #(
        .P_NCH     (C_NCH),
        .P_CNT_MAX (4),
        .P_CNT_W   (3)
    ) u_dut (
        .clk     (clk),
        .rstb    (rstb),
        .i_swt   (i_swt),
        .o_swt   (o_swt),
        .o_rise  (o_rise),
        .o_fall  (o_fall),
        .o_latch (o_latch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance n cycles; each cycle the level and latch must hold and no
    // edge pulse may appear.
    task automatic hold(input int n, input logic [3:0] swt_exp, input logic [3:0] latch_exp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val("hold_swt",   o_swt,   swt_exp);
            check_val("hold_rise",  o_rise,  4'b0000);
            check_val("hold_fall",  o_fall,  4'b0000);
            check_val("hold_latch", o_latch, latch_exp);
        end
    endtask

    // One cycle, then check all four outputs.
    task automatic step_all(input string tag, input logic [3:0] swt_exp, input logic [3:0] rise_exp,
                            input logic [3:0] fall_exp, input logic [3:0] latch_exp);
        @(negedge clk);
        check_val({tag, "_swt"},   o_swt,   swt_exp);
        check_val({tag, "_rise"},  o_rise,  rise_exp);
        check_val({tag, "_fall"},  o_fall,  fall_exp);
        check_val({tag, "_latch"}, o_latch, latch_exp);
    endtask

    initial begin
        rstb  = 1'b0;
        i_swt = 4'b0000;
        repeat (3) @(negedge clk);
        check_val("rst_swt",   o_swt,   4'b0000);
        check_val("rst_rise",  o_rise,  4'b0000);
        check_val("rst_fall",  o_fall,  4'b0000);
        check_val("rst_latch", o_latch, 4'b0000);
        rstb = 1'b1;
        @(negedge clk);

        // 1. Clean rise on channel 0: edges 1..5 quiet, edge 6 rises.
        i_swt = 4'b0001;
        hold(5, 4'b0000, 4'b0000);
        step_all("t1_e6", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        hold(1, 4'b0001, 4'b0001);

        // 2. Bounce on channel 1: 3 high, 2 low, 3 high, then low -> no effect.
        i_swt = 4'b0011; hold(3, 4'b0001, 4'b0001);
        i_swt = 4'b0001; hold(2, 4'b0001, 4'b0001);
        i_swt = 4'b0011; hold(3, 4'b0001, 4'b0001);
        i_swt = 4'b0001; hold(6, 4'b0001, 4'b0001);
        // Exactly 4 cycles high: qualifies on edge 6, falls back 4 edges later.
        i_swt = 4'b0011; hold(4, 4'b0001, 4'b0001);
        i_swt = 4'b0001; hold(1, 4'b0001, 4'b0001);
        step_all("t2_e6", 4'b0011, 4'b0010, 4'b0000, 4'b0011);
        hold(3, 4'b0011, 4'b0011);
        step_all("t2_e10", 4'b0001, 4'b0000, 4'b0010, 4'b0011);
        hold(2, 4'b0001, 4'b0011);

        // 3. Fall on channel 0 keeps latch; second press clears it.
        i_swt = 4'b0000; hold(5, 4'b0001, 4'b0011);
        step_all("t3_fall", 4'b0000, 4'b0000, 4'b0001, 4'b0011);
        hold(2, 4'b0000, 4'b0011);
        i_swt = 4'b0001; hold(5, 4'b0000, 4'b0011);
        step_all("t3_press2", 4'b0001, 4'b0001, 4'b0000, 4'b0010);
        hold(1, 4'b0001, 4'b0010);
        i_swt = 4'b0000; hold(5, 4'b0001, 4'b0010);
        step_all("t3_rel2", 4'b0000, 4'b0000, 4'b0001, 4'b0010);
        hold(1, 4'b0000, 4'b0010);

        // 4. All channels together.
        i_swt = 4'b1111; hold(5, 4'b0000, 4'b0010);
        step_all("t4_rise", 4'b1111, 4'b1111, 4'b0000, 4'b1101);
        hold(1, 4'b1111, 4'b1101);
        i_swt = 4'b0000; hold(5, 4'b1111, 4'b1101);
        step_all("t4_fall", 4'b0000, 4'b0000, 4'b1111, 4'b1101);
        hold(1, 4'b0000, 4'b1101);

        // 5. Reset mid-count on channel 2.
        i_swt = 4'b0100; hold(4, 4'b0000, 4'b1101);
        #2 rstb = 1'b0;
        #1;
        check_val("t5_async_swt",   o_swt,   4'b0000);
        check_val("t5_async_rise",  o_rise,  4'b0000);
        check_val("t5_async_fall",  o_fall,  4'b0000);
        check_val("t5_async_latch", o_latch, 4'b0000);
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        hold(5, 4'b0000, 4'b0000);
        step_all("t5_e6", 4'b0100, 4'b0100, 4'b0000, 4'b0100);
        hold(1, 4'b0100, 4'b0100);

        // 6. Input high through reset qualifies as a normal rise.
        rstb  = 1'b0;
        i_swt = 4'b1010;
        repeat (3) @(negedge clk);
        check_val("t6_rst_swt",   o_swt,   4'b0000);
        check_val("t6_rst_latch", o_latch, 4'b0000);
        rstb = 1'b1;
        hold(5, 4'b0000, 4'b0000);
        step_all("t6_e6", 4'b1010, 4'b1010, 4'b0000, 4'b1010);
        hold(1, 4'b1010, 4'b1010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/swt_debounce.md
# swt_debounce

Per-channel switch/button conditioner between the board slide switches and the LED-blink counter enables. Each channel synchronizes an asynchronous input into `clk`, rejects bounce shorter than a programmable stable time, and produces a clean level. It also produces single-cycle rise/fall pulses and a rise-toggled latch. `o_swt` drives the counter-toggle `ena` inputs directly. `o_latch` lets momentary buttons act as enables.

## Interface
- `P_NCH`, default 4: number of independent channels.
- `P_CNT_MAX`, default 1000000: stable cycles required, 10 ms at 100 MHz. Must be ≥1. Simulation overrides it to a small value.
- `P_CNT_W`, default 20: counter width. Must satisfy 2^P_CNT_W > P_CNT_MAX−1.
- `clk` input, 1 bit: single clock, rising edge.
- `rstb` input, 1 bit: reset, asynchronous, active-low. Every flop in the block clears when it is low.
- `i_swt` input, P_NCH bits: raw switch levels, asynchronous to `clk`.
- `o_swt` output, P_NCH bits: debounced level. Registered.
- `o_rise` output, P_NCH bits: one-cycle pulse when `o_swt[i]` goes 0→1.
- `o_fall` output, P_NCH bits: one-cycle pulse when `o_swt[i]` goes 1→0.
- `o_latch` output, P_NCH bits: toggles on every `o_rise[i]`.

## Operation
- **Reset values.** All outputs are 0, as are synchronizer flops and counters. Reset mid-count abandons the count.
- **Synchronizer.** Each channel has a 2-flop synchronizer: `i_swt` → s1 → s2. Only s2 is used downstream.
- **Per-channel counter `cnt`:**
  - If s2 == o_swt: cnt ← 0. Any bounce back restarts qualification.
  - If s2 != o_swt and cnt < P_CNT_MAX−1: cnt ← cnt+1.
  - If s2 != o_swt and cnt == P_CNT_MAX−1: o_swt ← s2 and cnt ← 0.
- **Arithmetic.** `cnt` never exceeds P_CNT_MAX−1, so no wrap is possible. The comparison is done at P_CNT_W bits.
- **Edge pulses.** `o_rise[i]` is 1 exactly in the first cycle that `o_swt[i]` is 1. `o_fall[i]` is 1 exactly in the first cycle that `o_swt[i]` is 0. Both are registered, never high together, and never high for two consecutive cycles on the same channel.
- **Latch.** `o_latch[i]` inverts in the same cycle `o_rise[i]` asserts. Falls do not affect it.
- **Channel independence.** Channels are fully independent; simultaneous events on several channels are each handled per the rules above.
- **Input high at reset release.** The channel qualifies as a normal rise, since o_swt resets to 0.

## Timing
- Number rising edges from 1, where edge 1 is the first edge that samples the new `i_swt` value.
- Edge 1 loads s1 and edge 2 loads s2. Edges 3 … P_CNT_MAX+2 count.
- `o_swt` changes on edge P_CNT_MAX+2, so latency is P_CNT_MAX+2 cycles. With P_CNT_MAX=1, latency is 3 cycles.
- **Filter threshold.** An input level held for L cycles:
  - L ≥ P_CNT_MAX: propagates.
  - L < P_CNT_MAX: no effect on any output.
- `o_rise`, `o_fall` and `o_latch` update on the same edge as `o_swt`. There is no added latency.
- A bounce restarts counting from 0. The required stable time is measured from the last transition seen at s2.

## Test plan
All tests use P_CNT_MAX=4, P_NCH=4.
1. **Clean rise.** Hold `rstb`=0 for 3 cycles, then release. Set `i_swt`=4'b0001 and hold it.
   - `o_swt[0]` goes 1 on edge 6 and no earlier.
   - `o_rise[0]`=1 for exactly that cycle.
   - `o_latch[0]`=1 from edge 6.
   - Other channels stay 0.
2. **Bounce rejection.** Drive `i_swt[1]` high for 3 cycles, low for 2, high for 3, then low.
   - `o_swt[1]`, `o_rise[1]` and `o_latch[1]` stay 0 throughout.
   - Then hold it high for exactly 4 cycles: `o_swt[1]` goes 1 for ≥1 cycle.
3. **Fall and latch.** After test 1, set `i_swt[0]`=0.
   - `o_swt[0]` goes 0 on edge 6.
   - `o_fall[0]` pulses for 1 cycle.
   - `o_latch[0]` stays 1.
   - A second clean press makes `o_latch[0]` return to 0.
4. **Simultaneous channels.** Drive `i_swt` 4'b0000→4'b1111 in one cycle.
   - All four `o_swt` bits and all four `o_rise` bits assert on the same edge 6.
5. **Reset mid-count.** Raise `i_swt[2]`, then assert `rstb`=0 asynchronously after 4 edges. Release 2 cycles later with `i_swt[2]` still high.
   - All outputs are 0 immediately on assertion.
   - `o_swt[2]` rises exactly 6 edges after release.
6. **High at reset.** Hold `i_swt`=4'b1010 during and after reset.
   - `o_swt`=4'b1010 with `o_rise`=4'b1010 pulsing on edge 6 after release.
